op_issue_decoder: RTL and testbench
===================================

Name: op_issue_decoder

Overview:
- Issue-side counterpart of the functional unit's priority encoder.
- Accepts 3-bit opcode + 3-bit operand-select commands through a valid/ready handshake and buffers them in a small FIFO.
- Decodes each opcode into the one-hot 8-bit instruction word the functional unit's encoder consumes.
- Presents instruction/select to the functional unit through a registered valid/ready output stage and counts issued instructions.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
- CW, 8, width of the issued-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO and output stage; issue_count is not affected.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  3  opcode 0..7.
- cmd_sel  input  3  operand select, passed through unmodified.
- out_valid  output  1  instruction/select valid.
- out_ready  input  1  functional unit consumes the output this cycle.
- instruction  output  8  one-hot decoded instruction.
- select  output  3  operand select for the functional unit.
- issue_count  output  CW  number of completed output transfers, modulo 2^CW.
- fifo_level  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO pointers and level go to 0.
  - out_valid=0, instruction=8'h00, select=3'b000, issue_count=0.
  - Reset overrides flush and every handshake in the same cycle.
  - Reset mid-transfer discards all buffered and presented commands.
- Decode: instruction = 8'b1 << cmd_op.
  - op0 -> 8'h01, op1 -> 8'h02, ..., op7 -> 8'h80.
  - Each value round-trips exactly through the functional unit's encoder.
  - op0 must never be issued as 8'h00.
- Push:
  - cmd_ready = (fifo_level != DEPTH); combinational from registered level only.
  - Push occurs when cmd_valid && cmd_ready.
  - Entry stored is {cmd_op, cmd_sel}.
- Pop / load:
  - load = (!out_valid || out_ready) && (fifo_level != 0).
  - On load, the head entry pops and the output registers take its decoded instruction and select; out_valid=1.
  - There is no FIFO bypass: a command pushed at edge N is first visible on the outputs after edge N+1.
  - Minimum latency is 2 edges from cmd_valid sampling to out_valid.
- Drain: if out_valid && out_ready and the FIFO is empty, out_valid goes 0 next cycle and instruction/select return to 8'h00/3'b000.
  - Rule: instruction is 8'h00 whenever out_valid=0.
- Stall: out_valid=1 && out_ready=0 holds instruction and select stable; no pop.
- Simultaneous push and pop in one cycle: fifo_level stays unchanged.
  - Sustained throughput is 1 command/cycle once primed.
- Full FIFO:
  - cmd_ready=0.
  - A pop in the same cycle does not enable a push that cycle; cmd_ready rises the following cycle.
- Pointers: read and write pointers wrap modulo DEPTH.
- issue_count: increments by 1 on every out_valid && out_ready edge; wraps from 2^CW-1 to 0.
- Flush (rst=0):
  - Empties the FIFO and clears the output stage to reset values.
  - A push in the flush cycle is discarded.
  - A transfer in the flush cycle still increments issue_count.
  - cmd_ready follows from the cleared level the next cycle.
- Control structure: output-stage FSM with states EMPTY (out_valid=0) and PRESENT (out_valid=1).
  - EMPTY->PRESENT on load.
  - PRESENT->EMPTY on transfer with empty FIFO, or on flush.
  - PRESENT->PRESENT on stall, or on transfer with a new load.

Test Plan:
- Reset, then push op=0,sel=011 with out_ready=1 -> out_valid rises 2 edges after push; instruction=8'h01, select=3'b011 for one cycle; issue_count=1; then instruction=8'h00.
- Push op 0..7 back-to-back with out_ready=1 -> instructions 01,02,04,08,10,20,40,80 on consecutive cycles; re-encoding each gives 0..7; issue_count=8.
- Hold out_ready=0 and push 5 commands with DEPTH=4 -> 4 commands accepted into the FIFO and a 5th loaded into the output stage; cmd_ready=0 with fifo_level=4 once full; output stable; releasing out_ready drains all in order with no loss or duplication.
- Full FIFO with out_ready=1 and cmd_valid=1 held -> no push in the pop cycle; push on the next cycle; fifo_level oscillates 4->3->4.
- 3 entries buffered, output presenting op=6, sel=110; assert flush with out_ready=0 -> next cycle out_valid=0, instruction=8'h00, fifo_level=0; issue_count unchanged.
- Issue 256 transfers with CW=8 -> issue_count wraps to 0; assert rst mid-stream -> all outputs at reset values the next cycle, including issue_count=0.

Source files
------------

// File: rtl/op_issue_decoder.sv
// Issue-side opcode decoder: buffers {op, sel} commands in a small FIFO and
// presents one-hot instructions through a registered valid/ready output stage.
module op_issue_decoder #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [2:0]               cmd_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               instruction,
    output logic [2:0]               select,
    output logic [CW-1:0]            issue_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        EMPTY   = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      instr_q, instr_d;
    logic [2:0]      sel_q, sel_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [5:0]      mem_q [DEPTH];

    logic            push;
    logic            load;
    logic            xfer;
    logic [5:0]      head;

    function automatic logic [7:0] decode_op(input logic [2:0] op);
        decode_op = 8'h01 << op;
    endfunction

    assign cmd_ready   = (level_q != LW'(DEPTH));
    assign out_valid   = (state_q == PRESENT);
    assign instruction = instr_q;
    assign select      = sel_q;
    assign issue_count = count_q;
    assign fifo_level  = level_q;

    assign push = cmd_valid && cmd_ready && !flush;
    assign load = (!out_valid || out_ready) && (level_q != '0);
    assign xfer = out_valid && out_ready;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        sel_d    = sel_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // A transfer in the flush cycle still counts as issued.
        count_d  = count_q + CW'(xfer);

        if (flush) begin
            state_d  = EMPTY;
            instr_d  = 8'h00;
            sel_d    = 3'b000;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (load) rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(push) - LW'(load);

            case (state_q)
                EMPTY: begin
                    if (load) begin
                        state_d = PRESENT;
                        instr_d = decode_op(head[5:3]);
                        sel_d   = head[2:0];
                    end
                end
                PRESENT: begin
                    if (load) begin
                        instr_d = decode_op(head[5:3]);
                        sel_d   = head[2:0];
                    end else if (out_ready) begin
                        state_d = EMPTY;
                        instr_d = 8'h00;
                        sel_d   = 3'b000;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            instr_q  <= 8'h00;
            sel_q    <= 3'b000;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            sel_q    <= sel_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_sel};
    end

endmodule

// File: tb/tb_op_issue_decoder.sv
// Directed bench for op_issue_decoder (DEPTH=4, CW=8).
module tb_op_issue_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] instruction;
    logic [2:0] select;
    logic [7:0] issue_count;
    logic [2:0] fifo_level;

    int errors = 0;
    int checks = 0;

    logic [7:0] onehot_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                   8'h10, 8'h20, 8'h40, 8'h80};

    op_issue_decoder #(.DEPTH(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .instruction(instruction), .select(select),
        .issue_count(issue_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0;
        cmd_sel = 3'd0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++;
        if ({out_valid, instruction, select, issue_count, fifo_level, cmd_ready} !== {1'b0, 8'h00, 3'b000, 8'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got v=%b ins=%h sel=%b cnt=%0d lvl=%0d rdy=%b, expected 0 00 000 0 0 1",
                     out_valid, instruction, select, issue_count, fifo_level, cmd_ready);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_sel = 3'b011;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL single_no_bypass: got v=%b lvl=%0d, expected v=0 lvl=1", out_valid, fifo_level);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || instruction !== 8'h01 || select !== 3'b011) begin
            errors++;
            $display("FAIL single_present: got v=%b ins=%h sel=%b, expected v=1 ins=01 sel=011",
                     out_valid, instruction, select);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || instruction !== 8'h00 || select !== 3'b000 || issue_count !== 8'd1) begin
            errors++;
            $display("FAIL single_drain: got v=%b ins=%h sel=%b cnt=%0d, expected v=0 ins=00 sel=000 cnt=1",
                     out_valid, instruction, select, issue_count);
        end
    endtask

    task automatic test_back_to_back();
        int enc;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                cmd_valid = 1'b1; cmd_op = 3'(i); cmd_sel = 3'(7 - i);
            end else begin
                cmd_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 8) begin
                enc = -1;
                for (int b = 0; b < 8; b++) if (instruction == onehot_tab[b]) enc = b;
                checks++;
                if (out_valid !== 1'b1 || instruction !== onehot_tab[i-1] || select !== 3'(8 - i) || enc != i - 1) begin
                    errors++;
                    $display("FAIL b2b_op%0d: got v=%b ins=%h sel=%0d enc=%0d, expected v=1 ins=%h sel=%0d enc=%0d",
                             i - 1, out_valid, instruction, select, enc, onehot_tab[i-1], 8 - i, i - 1);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b0 || issue_count !== 8'd9) begin
            errors++;
            $display("FAIL b2b_count: got v=%b cnt=%0d, expected v=0 cnt=9", out_valid, issue_count);
        end
    endtask

    task automatic test_full_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'(i + 1); cmd_sel = 3'(i);
            step();
        end
        cmd_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4 || cmd_ready !== 1'b0 || out_valid !== 1'b1 || instruction !== 8'h02 || select !== 3'd0) begin
            errors++;
            $display("FAIL full_state: got lvl=%0d rdy=%b v=%b ins=%h sel=%0d, expected 4 0 1 02 0",
                     fifo_level, cmd_ready, out_valid, instruction, select);
        end
        step(); step();
        checks++;
        if (instruction !== 8'h02 || select !== 3'd0 || fifo_level !== 3'd4 || issue_count !== 8'd9) begin
            errors++;
            $display("FAIL stall_hold: got ins=%h sel=%0d lvl=%0d cnt=%0d, expected 02 0 4 9",
                     instruction, select, fifo_level, issue_count);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || instruction !== onehot_tab[k+1] || select !== 3'(k) || fifo_level !== 3'(4 - k)) begin
                errors++;
                $display("FAIL drain_%0d: got v=%b ins=%h sel=%0d lvl=%0d, expected 1 %h %0d %0d",
                         k, out_valid, instruction, select, fifo_level, onehot_tab[k+1], k, 4 - k);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || instruction !== 8'h00 || issue_count !== 8'd14) begin
            errors++;
            $display("FAIL drain_end: got v=%b ins=%h cnt=%0d, expected 0 00 14", out_valid, instruction, issue_count);
        end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'(i + 2); cmd_sel = 3'(i);
            step();
        end
        cmd_op = 3'd7; cmd_sel = 3'd7;
        out_ready = 1'b1;
        step();
        checks++;
        if (fifo_level !== 3'd3 || cmd_ready !== 1'b1 || instruction !== 8'h08) begin
            errors++;
            $display("FAIL full_pop_no_push: got lvl=%0d rdy=%b ins=%h, expected 3 1 08", fifo_level, cmd_ready, instruction);
        end
        out_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4 || cmd_ready !== 1'b0 || issue_count !== 8'd15) begin
            errors++;
            $display("FAIL full_repush: got lvl=%0d rdy=%b cnt=%0d, expected 4 0 15", fifo_level, cmd_ready, issue_count);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_sel = 3'd1;
        flush = 1'b1;
        step();
        flush = 1'b0; cmd_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || instruction !== 8'h00 || fifo_level !== 3'd0 || cmd_ready !== 1'b1 || issue_count !== 8'd15) begin
            errors++;
            $display("FAIL flush_full: got v=%b ins=%h lvl=%0d rdy=%b cnt=%0d, expected 0 00 0 1 15",
                     out_valid, instruction, fifo_level, cmd_ready, issue_count);
        end
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_op  = (i == 0) ? 3'd6 : 3'(i);
            cmd_sel = (i == 0) ? 3'b110 : 3'(i);
            step();
        end
        cmd_valid = 1'b0;
        checks++;
        if (instruction !== 8'h40 || select !== 3'b110 || fifo_level !== 3'd3) begin
            errors++;
            $display("FAIL flush_setup: got ins=%h sel=%b lvl=%0d, expected 40 110 3", instruction, select, fifo_level);
        end
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || instruction !== 8'h00 || select !== 3'b000 || fifo_level !== 3'd0 || issue_count !== 8'd16) begin
            errors++;
            $display("FAIL flush_xfer: got v=%b ins=%h sel=%b lvl=%0d cnt=%0d, expected 0 00 000 0 16",
                     out_valid, instruction, select, fifo_level, issue_count);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL flush_after: got v=%b lvl=%0d, expected 0 0", out_valid, fifo_level);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [7:0] exp_cnt = 8'd16;
        logic       xfer;
        logic       wrapped = 1'b0;
        out_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd5; cmd_sel = 3'd2;
        for (int c = 0; c < 400 && !wrapped; c++) begin
            xfer = (out_valid === 1'b1);
            step();
            if (xfer) exp_cnt = exp_cnt + 8'd1;
            checks++;
            if (issue_count !== exp_cnt) begin
                errors++;
                $display("FAIL wrap_count_c%0d: got %0d, expected %0d", c, issue_count, exp_cnt);
            end
            if (xfer && exp_cnt == 8'd0) wrapped = 1'b1;
        end
        checks++;
        if (!wrapped) begin
            errors++;
            $display("FAIL wrap_timeout: got no wrap within 400 cycles, expected issue_count to reach 0");
        end
        step(); step();
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        checks++;
        if ({out_valid, instruction, select, issue_count, fifo_level, cmd_ready} !== {1'b0, 8'h00, 3'b000, 8'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL midstream_reset: got v=%b ins=%h sel=%b cnt=%0d lvl=%0d rdy=%b, expected 0 00 000 0 0 1",
                     out_valid, instruction, select, issue_count, fifo_level, cmd_ready);
        end
        cmd_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_discard: got v=%b lvl=%0d, expected 0 0", out_valid, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_stall();
        test_full_pop();
        test_flush();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
